// File: rtl/awg_pkg.sv
// ============================================================================
// Module   : awg_pkg
// Brief    : Shared constants, types and helpers for the AWG command decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package awg_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;

  localparam logic [7:0] CMD_TYPE   = 8'h01;
  localparam logic [7:0] CMD_FREQ   = 8'h02;
  localparam logic [7:0] CMD_AMP    = 8'h03;
  localparam logic [7:0] CMD_OFFSET = 8'h04;
  localparam logic [7:0] CMD_ALL    = 8'h05;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_CMD    = 2'd1;
  localparam logic [1:0] ERR_CHK    = 2'd2;
  localparam logic [1:0] ERR_TMO    = 2'd3;

  localparam int TYPE_W   = 2;
  localparam int FREQ_W   = 17;
  localparam int AMP_W    = 10;
  localparam int OFFSET_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  // Payload byte count per command; zero marks an unknown command code.
  function automatic logic [3:0] payload_len(input logic [7:0] cmd);
    case (cmd)
      CMD_TYPE:   payload_len = 4'd1;
      CMD_FREQ:   payload_len = 4'd3;
      CMD_AMP:    payload_len = 4'd2;
      CMD_OFFSET: payload_len = 4'd2;
      CMD_ALL:    payload_len = 4'd8;
      default:    payload_len = 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/awg_byte_timeout.sv
// ============================================================================
// Module   : awg_byte_timeout
// Brief    : Inter-byte watchdog; flags expiry after TIMEOUT_CYCLES idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module awg_byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned        CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != C_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A byte in the expiry cycle suppresses the timeout.
  assign o_expired = i_run && !i_clear && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/awg_cmd_decoder.sv
// ============================================================================
// Module   : awg_cmd_decoder
// Brief    : Framed UART command parser holding the live waveform settings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module awg_cmd_decoder
  import awg_pkg::*;
#(
  parameter int unsigned          TIMEOUT_CYCLES = 100000,
  parameter logic [FREQ_W-1:0]    RST_FREQ       = 17'd1000,
  parameter logic [AMP_W-1:0]     RST_AMP        = 10'h3FF,
  parameter logic [OFFSET_W-1:0]  RST_OFFSET     = 10'h200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [TYPE_W-1:0]    waveform_type,
  output logic [FREQ_W-1:0]    frequency,
  output logic [AMP_W-1:0]     amplitude,
  output logic [OFFSET_W-1:0]  dc_offset,
  output logic                 cfg_update,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 busy
);

  state_t      r_state;
  logic [7:0]  r_cmd;
  logic [7:0]  r_xor;
  logic [3:0]  r_left;
  logic [63:0] r_shadow;
  logic        w_expired;
  logic [3:0]  w_len;

  assign w_len = payload_len(rx_data);

  awg_byte_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (rx_valid),
    .i_run     (r_state != ST_IDLE),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_xor         <= '0;
      r_left        <= '0;
      r_shadow      <= '0;
      waveform_type <= '0;
      frequency     <= RST_FREQ;
      amplitude     <= RST_AMP;
      dc_offset     <= RST_OFFSET;
      cfg_update    <= 1'b0;
      err           <= 1'b0;
      err_code      <= ERR_NONE;
      busy          <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      err        <= 1'b0;
      if (w_expired) begin
        err      <= 1'b1;
        err_code <= ERR_TMO;
        r_state  <= ST_IDLE;
        busy     <= 1'b0;
      end else if (rx_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              r_state <= ST_CMD;
              busy    <= 1'b1;
            end
          end
          ST_CMD: begin
            // A repeated sync byte lands here as an unknown command.
            if (w_len != 4'd0) begin
              r_cmd    <= rx_data;
              r_xor    <= rx_data;
              r_left   <= w_len;
              r_shadow <= '0;
              r_state  <= ST_PAYLOAD;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_CMD;
              r_state  <= ST_IDLE;
              busy     <= 1'b0;
            end
          end
          ST_PAYLOAD: begin
            r_shadow <= {r_shadow[55:0], rx_data};
            r_xor    <= r_xor ^ rx_data;
            r_left   <= r_left - 1'b1;
            if (r_left == 4'd1) begin
              r_state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            if (rx_data == r_xor) begin
              cfg_update <= 1'b1;
              // Last payload byte sits in r_shadow[7:0].
              case (r_cmd)
                CMD_TYPE:   waveform_type <= r_shadow[TYPE_W-1:0];
                CMD_FREQ:   frequency     <= r_shadow[FREQ_W-1:0];
                CMD_AMP:    amplitude     <= r_shadow[AMP_W-1:0];
                CMD_OFFSET: dc_offset     <= r_shadow[OFFSET_W-1:0];
                CMD_ALL: begin
                  waveform_type <= r_shadow[56 +: TYPE_W];
                  frequency     <= r_shadow[32 +: FREQ_W];
                  amplitude     <= r_shadow[16 +: AMP_W];
                  dc_offset     <= r_shadow[0  +: OFFSET_W];
                end
                default: cfg_update <= 1'b0;
              endcase
            end else begin
              err      <= 1'b1;
              err_code <= ERR_CHK;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_awg_cmd_decoder.sv
// ============================================================================
// Module   : tb_awg_cmd_decoder
// Brief    : Directed self-checking bench for awg_cmd_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_awg_cmd_decoder;

  localparam int unsigned C_TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [1:0]  waveform_type;
  logic [16:0] frequency;
  logic [9:0]  amplitude;
  logic [9:0]  dc_offset;
  logic        cfg_update;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  awg_cmd_decoder #(
    .TIMEOUT_CYCLES (C_TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .waveform_type (waveform_type),
    .frequency     (frequency),
    .amplitude     (amplitude),
    .dc_offset     (dc_offset),
    .cfg_update    (cfg_update),
    .err           (err),
    .err_code      (err_code),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_live(input string tag, input logic [1:0] t, input logic [16:0] f,
                            input logic [9:0] a, input logic [9:0] o);
    check({tag, ".type"}, 32'(waveform_type), 32'(t));
    check({tag, ".freq"}, 32'(frequency), 32'(f));
    check({tag, ".amp"},  32'(amplitude), 32'(a));
    check({tag, ".off"},  32'(dc_offset), 32'(o));
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_live("reset", 2'd0, 17'd1000, 10'h3FF, 10'h200);
    check("reset.cfg",  32'(cfg_update), 32'd0);
    check("reset.err",  32'(err), 32'd0);
    check("reset.code", 32'(err_code), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);

    // Frequency write
    send(8'hA5); check("freq.busy", 32'(busy), 32'd1);
    send(8'h02); send(8'h00); send(8'h12); send(8'h34); send(8'h24);
    check("freq.cfg", 32'(cfg_update), 32'd1);
    check_live("freq", 2'd0, 17'h01234, 10'h3FF, 10'h200);
    check("freq.busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    check("freq.cfg_pulse", 32'(cfg_update), 32'd0);

    // Amplitude write, then immediately a bad checksum
    send(8'hA5); send(8'h03); send(8'h02); send(8'hAB); send(8'hAA);
    check("amp.cfg", 32'(cfg_update), 32'd1);
    check("amp.val", 32'(amplitude), 32'h2AB);
    send(8'hA5); send(8'h03); send(8'h02); send(8'hAB); send(8'hAB);
    check("chk.err",  32'(err), 32'd1);
    check("chk.code", 32'(err_code), 32'd2);
    check("chk.cfg",  32'(cfg_update), 32'd0);
    check("chk.amp",  32'(amplitude), 32'h2AB);
    @(negedge clk);
    check("chk.err_pulse", 32'(err), 32'd0);
    check("chk.code_hold", 32'(err_code), 32'd2);

    // Invalid command, then recovery
    send(8'hA5); send(8'h7F);
    check("cmd.err",  32'(err), 32'd1);
    check("cmd.code", 32'(err_code), 32'd1);
    check("cmd.busy", 32'(busy), 32'd0);
    send(8'hA5); send(8'h01); send(8'h03); send(8'h02);
    check("type.cfg", 32'(cfg_update), 32'd1);
    check_live("type", 2'd3, 17'h01234, 10'h2AB, 10'h200);
    check("type.code_hold", 32'(err_code), 32'd1);

    // Sync inside CMD is an invalid command
    send(8'hA5); send(8'hA5);
    check("resync.code", 32'(err_code), 32'd1);
    check("resync.busy", 32'(busy), 32'd0);

    // Timeout: error after C_TMO silent cycles, not before
    send(8'hA5); send(8'h02); send(8'h03);
    repeat (C_TMO - 1) @(negedge clk);
    check("tmo.early_err",  32'(err), 32'd0);
    check("tmo.early_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo.err",  32'(err), 32'd1);
    check("tmo.code", 32'(err_code), 32'd3);
    check("tmo.busy", 32'(busy), 32'd0);
    check("tmo.freq", 32'(frequency), 32'h01234);

    // Byte landing in the expiry cycle wins; upper freq bits dropped
    send(8'hA5); send(8'h02); send(8'h03);
    repeat (C_TMO - 1) @(negedge clk);
    send(8'h56);
    check("edge.err",  32'(err), 32'd0);
    check("edge.busy", 32'(busy), 32'd1);
    send(8'h78); send(8'h2F);
    check("edge.cfg",  32'(cfg_update), 32'd1);
    check("edge.freq", 32'(frequency), 32'h15678);

    // Full configuration in one packet
    send(8'hA5); send(8'h05);
    send(8'h02); send(8'h00); send(8'h00); send(8'h64);
    send(8'h01); send(8'h00); send(8'h00); send(8'h80);
    check_live("all.pre", 2'd3, 17'h15678, 10'h2AB, 10'h200);
    send(8'hE2);
    check("all.cfg", 32'(cfg_update), 32'd1);
    check_live("all", 2'd2, 17'd100, 10'h100, 10'h080);
    @(negedge clk);
    check("all.cfg_pulse", 32'(cfg_update), 32'd0);

    // Reset mid-packet; trailing bytes must be ignored from IDLE
    send(8'hA5); send(8'h05); send(8'h01); send(8'h00);
    check("rstmid.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_live("rstmid", 2'd0, 17'd1000, 10'h3FF, 10'h200);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.code", 32'(err_code), 32'd0);
    send(8'h00); send(8'h12); send(8'h01); send(8'h00); send(8'h00);
    send(8'h80); send(8'h94);
    check("rstmid.tail_busy", 32'(busy), 32'd0);
    check("rstmid.tail_cfg",  32'(cfg_update), 32'd0);
    check("rstmid.tail_freq", 32'(frequency), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
